// File: rtl/pipe3_arbiter.sv
// Round-robin arbiter feeding a fixed 3-stage tagged pipeline; a beat accepted in cycle t is at the output in t+3.
// The pipe shifts or holds as a whole: it stalls only while stage 3 holds a beat that out_ready_i refuses.
module pipe3_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*WIDTH-1:0]   req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic                    flush_i,
  input  logic                    out_ready_i,
  output logic                    out_valid_o,
  output logic [WIDTH-1:0]        out_data_o,
  output logic [$clog2(NREQ)-1:0] out_id_o,
  output logic                    busy_o
);
  localparam int IDW = $clog2(NREQ);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] dat;
    logic [IDW-1:0]   id;
  } stage_t;

  stage_t           s1_q, s2_q, s3_q;
  stage_t           s1_d, s2_d, s3_d;
  logic [IDW-1:0]   last_q, last_d;

  logic [WIDTH-1:0] req_dat [NREQ];
  logic             advance;
  logic             grant_ok;
  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   cand;
  int               idx;

  for (genvar r = 0; r < NREQ; r++) begin : g_unpack
    assign req_dat[r] = req_data_i[r*WIDTH +: WIDTH];
  end

  assign advance  = !s3_q.vld || out_ready_i;
  assign grant_ok = advance && !flush_i && !rst;

  // Search starts one past the last winner; the modulo keeps non-power-of-two NREQ in range.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx  = (int'(last_q) + i) % NREQ;
      cand = IDW'(idx);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_ok && found) begin
      req_ready_o[win] = 1'b1;
    end
  end

  always_comb begin
    s1_d   = s1_q;
    s2_d   = s2_q;
    s3_d   = s3_q;
    last_d = last_q;
    if (flush_i) begin
      s1_d.vld = 1'b0;
      s2_d.vld = 1'b0;
      s3_d.vld = 1'b0;
    end else if (advance) begin
      s3_d     = s2_q;
      s2_d     = s1_q;
      s1_d.vld = found;
      if (found) begin
        s1_d.dat = req_dat[win];
        s1_d.id  = win;
        last_d   = win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      last_q <= IDW'(NREQ - 1);
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      last_q <= last_d;
    end
  end

  assign out_valid_o = s3_q.vld;
  assign out_data_o  = s3_q.dat;
  assign out_id_o    = s3_q.id;
  assign busy_o      = s1_q.vld || s2_q.vld || s3_q.vld;

endmodule

// File: tb/tb_pipe3_arbiter.sv
// Bench for pipe3_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_pipe3_arbiter;
  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ*WIDTH-1:0] req_data_i;
  logic [NREQ-1:0]       req_ready_o;
  logic                  flush_i;
  logic                  out_ready_i;
  logic                  out_valid_o;
  logic [WIDTH-1:0]      out_data_o;
  logic [IDW-1:0]        out_id_o;
  logic                  busy_o;

  int checks   = 0;
  int failures = 0;

  pipe3_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .flush_i     (flush_i),
    .out_ready_i (out_ready_i),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_id_o    (out_id_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    req_valid_i = '0;
    req_data_i  = '0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;
  endtask

  task automatic pulse_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    req_valid_i = '1;
    tick();
    tick();
    settle();
    checks++; if (out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
    checks++; if (out_data_o !== 4'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data_o); end
    checks++; if (out_id_o !== 2'd0) begin failures++; $display("FAIL reset_out_id got=%0d exp=0", out_id_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++; if (req_ready_o !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o); end
  endtask

  task automatic test_single_beat();
    rst = 1'b0;
    idle();
    req_valid_i = 4'b0100;
    req_data_i[8 +: 4] = 4'hA;
    settle();
    checks++; if (req_ready_o !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready_o); end
    for (int cyc = 1; cyc <= 5; cyc++) begin
      tick();
      if (cyc == 1) idle();
      settle();
      checks++;
      if (out_valid_o !== (cyc == 3)) begin
        failures++; $display("FAIL single_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid_o, cyc == 3);
      end
      checks++;
      if (busy_o !== (cyc <= 3)) begin
        failures++; $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, busy_o, cyc <= 3);
      end
      if (cyc == 3) begin
        checks++;
        if (out_data_o !== 4'hA || out_id_o !== 2'd2) begin
          failures++; $display("FAIL single_out_beat got=%h/%0d exp=a/2", out_data_o, out_id_o);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_rdy;
    int              exp_id;
    pulse_reset();
    req_valid_i = '1;
    req_data_i  = 16'h4321;
    for (int cyc = 0; cyc < 8; cyc++) begin
      settle();
      exp_rdy = 4'b0001 << (cyc % 4);
      checks++;
      if (req_ready_o !== exp_rdy) begin
        failures++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, req_ready_o, exp_rdy);
      end
      checks++;
      if (out_valid_o !== (cyc >= 3)) begin
        failures++; $display("FAIL rr_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid_o, cyc >= 3);
      end
      if (cyc >= 3) begin
        exp_id = (cyc - 3) % 4;
        checks++;
        if (out_id_o !== IDW'(exp_id) || out_data_o !== WIDTH'(exp_id + 1)) begin
          failures++; $display("FAIL rr_out_beat cyc=%0d got=%h/%0d exp=%h/%0d", cyc, out_data_o, out_id_o, exp_id + 1, exp_id);
        end
      end
      tick();
    end
    idle();
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    for (int c = 0; c < 3; c++) begin
      req_valid_i = 4'b0001;
      req_data_i  = 16'(5 + c);
      settle();
      checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("FAIL bp_fill_ready c=%0d got=%b exp=0001", c, req_ready_o); end
      tick();
    end
    req_data_i  = 16'h0008;
    out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== 4'h5) begin
        failures++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/5", c, out_valid_o, out_data_o);
      end
      checks++; if (req_ready_o !== 4'b0000) begin failures++; $display("FAIL bp_ready c=%0d got=%b exp=0000", c, req_ready_o); end
      tick();
    end
    idle();
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if (out_valid_o !== (c < 3) || (c < 3 && out_data_o !== WIDTH'(5 + c))) begin
        failures++; $display("FAIL bp_drain c=%0d got=%b/%h exp=%b/%h", c, out_valid_o, out_data_o, c < 3, 5 + c);
      end
      tick();
    end
  endtask

  task automatic test_bubble_fill();
    pulse_reset();
    req_valid_i = 4'b0010;
    req_data_i  = 16'h0090;
    tick();
    idle();
    out_ready_i = 1'b0;
    settle();
    checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL bubble_s1 got=%b/%b exp=0/1", out_valid_o, busy_o); end
    tick();
    tick();
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== 4'h9 || out_id_o !== 2'd1) begin
        failures++; $display("FAIL bubble_s3 c=%0d got=%b/%h/%0d exp=1/9/1", c, out_valid_o, out_data_o, out_id_o);
      end
      tick();
    end
    out_ready_i = 1'b1;
    tick();
    checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL bubble_drain got=%b/%b exp=0/0", out_valid_o, busy_o); end
  endtask

  task automatic test_flush();
    pulse_reset();
    req_valid_i = 4'b0010;
    req_data_i  = 16'h00B0;
    settle();
    checks++; if (req_ready_o !== 4'b0010) begin failures++; $display("FAIL flush_grant1 got=%b exp=0010", req_ready_o); end
    tick();
    req_valid_i = 4'b1000;
    req_data_i  = 16'hC000;
    settle();
    checks++; if (req_ready_o !== 4'b1000) begin failures++; $display("FAIL flush_grant3 got=%b exp=1000", req_ready_o); end
    tick();
    flush_i     = 1'b1;
    req_valid_i = 4'b0001;
    settle();
    checks++; if (req_ready_o !== 4'b0000) begin failures++; $display("FAIL flush_ready got=%b exp=0000", req_ready_o); end
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL flush_busy_before got=%b exp=1", busy_o); end
    tick();
    flush_i     = 1'b0;
    req_valid_i = 4'b0011;
    settle();
    checks++; if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b/%b exp=0/0", busy_o, out_valid_o); end
    checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("FAIL flush_pointer got=%b exp=0001", req_ready_o); end
    tick();
    idle();
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    req_valid_i = '1;
    req_data_i  = 16'hFEDC;
    repeat (5) tick();
    rst = 1'b1;
    settle();
    checks++; if (req_ready_o !== 4'b0000) begin failures++; $display("FAIL rstmid_ready_in_rst got=%b exp=0000", req_ready_o); end
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== 4'h0 || out_id_o !== 2'd0 || busy_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_outputs got=%b/%h/%0d/%b exp=0/0/0/0", out_valid_o, out_data_o, out_id_o, busy_o);
    end
    checks++; if (req_ready_o !== 4'b0001) begin failures++; $display("FAIL rstmid_first_grant got=%b exp=0001", req_ready_o); end
    tick();
    idle();
    repeat (4) tick();
  endtask

  task automatic test_random();
    bit                    mv [3];
    logic [WIDTH-1:0]      md [3];
    int                    mi [3];
    int                    mlast;
    int                    win;
    bit                    adv;
    logic [NREQ-1:0]       exp_rdy;
    logic [NREQ-1:0]       vshift;
    logic [NREQ*WIDTH-1:0] dshift;
    pulse_reset();
    for (int s = 0; s < 3; s++) begin
      mv[s] = 1'b0; md[s] = '0; mi[s] = 0;
    end
    mlast = NREQ - 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst         = ($urandom_range(63) == 0);
      flush_i     = ($urandom_range(15) == 0);
      out_ready_i = ($urandom_range(9) < 7);
      req_valid_i = NREQ'($urandom);
      req_data_i  = (NREQ*WIDTH)'($urandom);
      settle();
      adv = !mv[2] || out_ready_i;
      win = -1;
      for (int k = 1; k <= NREQ; k++) begin
        vshift = req_valid_i >> ((mlast + k) % NREQ);
        if (win < 0 && vshift[0]) win = (mlast + k) % NREQ;
      end
      exp_rdy = '0;
      if (adv && !flush_i && !rst && win >= 0) exp_rdy = NREQ'(1) << win;
      checks++;
      if (req_ready_o !== exp_rdy) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready_o, exp_rdy);
      end
      checks++;
      if (out_valid_o !== mv[2]) begin
        failures++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", cyc, out_valid_o, mv[2]);
      end
      if (mv[2]) begin
        checks++;
        if (out_data_o !== md[2] || out_id_o !== IDW'(mi[2])) begin
          failures++; $display("FAIL rand_out_beat cyc=%0d got=%h/%0d exp=%h/%0d", cyc, out_data_o, out_id_o, md[2], mi[2]);
        end
      end
      checks++;
      if (busy_o !== (mv[0] | mv[1] | mv[2])) begin
        failures++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy_o, mv[0] | mv[1] | mv[2]);
      end
      if (rst) begin
        for (int s = 0; s < 3; s++) begin
          mv[s] = 1'b0; md[s] = '0; mi[s] = 0;
        end
        mlast = NREQ - 1;
      end else if (flush_i) begin
        for (int s = 0; s < 3; s++) mv[s] = 1'b0;
      end else if (adv) begin
        mv[2] = mv[1]; md[2] = md[1]; mi[2] = mi[1];
        mv[1] = mv[0]; md[1] = md[0]; mi[1] = mi[0];
        mv[0] = (win >= 0);
        if (win >= 0) begin
          dshift = req_data_i >> (win * WIDTH);
          md[0]  = dshift[WIDTH-1:0];
          mi[0]  = win;
          mlast  = win;
        end
      end
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_beat();
    test_round_robin();
    test_backpressure();
    test_bubble_fill();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
